// File: rtl/axil_pkg.sv
// Shared AXI4-Lite slave typedefs and constants: response codes, read-channel
// FSM states and the default local-wait timeout.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    LOC_WAIT    = 2'b01,
    RVALID_HOLD = 2'b10
  } axil_rd_state_e;

  localparam int AXIL_TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Cycle counter that flags expiry on the LIMIT-th enabled cycle after a clear.
module axil_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Expiry is combinational so the owner can react on the same edge.
  assign o_expire = i_enable && (r_cnt == CW'(LIMIT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/axils_rd_ch.sv
// AXI4-Lite slave read channel bridging AR/R to a simple local read strobe/ack
// port. Optional LOC_WAIT timeout is built when AXILS_RD_TIMEOUT_EN is defined.
module axils_rd_ch
  import axil_pkg::*;
#(
  parameter int TIMEOUT_CYC = AXIL_TIMEOUT_CYC_DEF
) (
  input  logic        ARESETn,
  input  logic        ACLK,
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  output logic        LOC_RE,
  output logic [31:0] LOC_ADDR,
  input  logic [31:0] LOC_RDATA,
  input  logic        LOC_RACK,
  input  logic        LOC_RERR
);

  axil_rd_state_e r_state, w_state_nxt;
  logic [31:0]    r_rdata, w_rdata_nxt;
  axil_resp_e     r_rresp, w_rresp_nxt;
  logic           r_rvalid, w_rvalid_nxt;
  logic           r_loc_re, w_loc_re_nxt;
  logic [31:0]    r_loc_addr, w_loc_addr_nxt;
  logic           w_timeout;
  logic           w_unused;

  assign w_unused = ^{ARPROT, ARADDR[1:0], TIMEOUT_CYC[0]};

`ifdef AXILS_RD_TIMEOUT_EN
  logic w_cnt_clr;
  logic w_cnt_en;

  assign w_cnt_clr = (r_state == IDLE) && ARVALID;
  assign w_cnt_en  = (r_state == LOC_WAIT);

  axil_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk    (ACLK),
    .i_rst_n  (ARESETn),
    .i_clear  (w_cnt_clr),
    .i_enable (w_cnt_en),
    .o_expire (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // ARREADY is gated by reset so it reads low for the whole reset interval.
  assign ARREADY  = ARESETn && (r_state == IDLE);
  assign RDATA    = r_rdata;
  assign RRESP    = r_rresp;
  assign RVALID   = r_rvalid;
  assign LOC_RE   = r_loc_re;
  assign LOC_ADDR = r_loc_addr;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= IDLE;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_loc_re   <= 1'b0;
      r_loc_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rdata    <= w_rdata_nxt;
      r_rresp    <= w_rresp_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_loc_re   <= w_loc_re_nxt;
      r_loc_addr <= w_loc_addr_nxt;
    end
  end

  // A local ack arriving on the timeout edge takes priority over the timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_rdata_nxt    = r_rdata;
    w_rresp_nxt    = r_rresp;
    w_rvalid_nxt   = r_rvalid;
    w_loc_re_nxt   = 1'b0;
    w_loc_addr_nxt = r_loc_addr;
    case (r_state)
      IDLE: begin
        if (ARVALID) begin
          w_loc_addr_nxt = {ARADDR[31:2], 2'b00};
          w_loc_re_nxt   = 1'b1;
          w_state_nxt    = LOC_WAIT;
        end
      end
      LOC_WAIT: begin
        if (LOC_RACK) begin
          w_rdata_nxt  = LOC_RDATA;
          w_rresp_nxt  = LOC_RERR ? RESP_SLVERR : RESP_OKAY;
          w_rvalid_nxt = 1'b1;
          w_state_nxt  = RVALID_HOLD;
        end else if (w_timeout) begin
          w_rdata_nxt  = '0;
          w_rresp_nxt  = RESP_SLVERR;
          w_rvalid_nxt = 1'b1;
          w_state_nxt  = RVALID_HOLD;
        end
      end
      RVALID_HOLD: begin
        if (RREADY) begin
          w_rvalid_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_rvalid_nxt = 1'b0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axils_rd_ch.sv
// Randomized self-checking bench for axils_rd_ch with a transaction-level model;
// timeout cases are exercised when AXILS_RD_TIMEOUT_EN is defined.
module tb_axils_rd_ch;

  localparam int TO = 16;

  logic        ARESETn;
  logic        ACLK;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        LOC_RE;
  logic [31:0] LOC_ADDR;
  logic [31:0] LOC_RDATA;
  logic        LOC_RACK;
  logic        LOC_RERR;

  int checkCount = 0;
  int failCount  = 0;

  axils_rd_ch #(
    .TIMEOUT_CYC (TO)
  ) dut (
    .ARESETn   (ARESETn),
    .ACLK      (ACLK),
    .ARADDR    (ARADDR),
    .ARPROT    (ARPROT),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .LOC_RE    (LOC_RE),
    .LOC_ADDR  (LOC_ADDR),
    .LOC_RDATA (LOC_RDATA),
    .LOC_RACK  (LOC_RACK),
    .LOC_RERR  (LOC_RERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Compares one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(1, 0));
  endfunction

  // One full read: d = idle-ack edges before LOC_RACK, bp = cycles RREADY held low.
  // The expected beat comes from the protocol rules: ack on LOC_WAIT edge d+1,
  // or a SLVERR/zero beat on edge TO if the ack would come later and the timeout exists.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic err, input int d, input int bp);
    int          nResp;
    int          n;
    logic        timedOut;
    logic [31:0] expData;
    logic [31:0] expAddr;
    logic [1:0]  expResp;
    timedOut = 1'b0;
    nResp    = d + 1;
`ifdef AXILS_RD_TIMEOUT_EN
    if (d >= TO) begin
      timedOut = 1'b1;
      nResp    = TO;
    end
`endif
    expData = timedOut ? 32'h0 : data;
    expResp = (timedOut || err) ? 2'b10 : 2'b00;
    expAddr = addr & 32'hFFFF_FFFC;

    checkOutput("arready_idle", 32'(ARREADY), 32'd1);
    ARVALID = 1'b1;
    ARADDR  = addr;
    ARPROT  = 3'($urandom);
    @(negedge ACLK);
    ARVALID = 1'b0;
    ARADDR  = $urandom;
    checkOutput("loc_re_pulse", 32'(LOC_RE), 32'd1);
    checkOutput("loc_addr", LOC_ADDR, expAddr);
    checkOutput("arready_busy", 32'(ARREADY), 32'd0);
    checkOutput("rvalid_early", 32'(RVALID), 32'd0);

    for (int k = 1; k <= nResp; k++) begin
      LOC_RACK  = (k == d + 1);
      LOC_RDATA = (k == d + 1) ? data : $urandom;
      LOC_RERR  = (k == d + 1) ? err : rbit();
      RREADY    = rbit();
      ARVALID   = rbit();
      @(negedge ACLK);
      if (k < nResp) begin
        checkOutput("rvalid_wait", 32'(RVALID), 32'd0);
        checkOutput("loc_re_once", 32'(LOC_RE), 32'd0);
        checkOutput("arready_wait", 32'(ARREADY), 32'd0);
      end
    end

    n = nResp;
    for (int h = 0; h <= bp; h++) begin
      checkOutput("rvalid_hold", 32'(RVALID), 32'd1);
      checkOutput("rdata", RDATA, expData);
      checkOutput("rresp", 32'(RRESP), 32'(expResp));
      checkOutput("arready_hold", 32'(ARREADY), 32'd0);
      n++;
      LOC_RACK  = (n == d + 1) || rbit();
      LOC_RDATA = $urandom;
      LOC_RERR  = rbit();
      ARVALID   = (h < bp) ? rbit() : 1'b0;
      RREADY    = (h == bp);
      @(negedge ACLK);
    end
    RREADY   = 1'b0;
    LOC_RACK = 1'b0;
    ARVALID  = 1'b0;
    checkOutput("rvalid_clear", 32'(RVALID), 32'd0);
    checkOutput("arready_back", 32'(ARREADY), 32'd1);
    checkOutput("loc_re_idle", 32'(LOC_RE), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_arready"}, 32'(ARREADY), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(RVALID), 32'd0);
    checkOutput({tag, "_loc_re"}, 32'(LOC_RE), 32'd0);
    checkOutput({tag, "_rdata"}, RDATA, 32'd0);
    checkOutput({tag, "_rresp"}, 32'(RRESP), 32'd0);
    checkOutput({tag, "_loc_addr"}, LOC_ADDR, 32'd0);
  endtask

  // Abort a read while waiting on the local side; no R beat may follow.
  task automatic resetMidRead();
    ARVALID = 1'b1;
    ARADDR  = 32'h0000_0A10;
    @(negedge ACLK);
    ARVALID  = 1'b0;
    LOC_RACK = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    checkResetValues("rst_mid");
    ARVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("rst_arready_forced", 32'(ARREADY), 32'd0);
    ARVALID = 1'b0;
    ARESETn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      LOC_RACK  = 1'b1;
      LOC_RDATA = $urandom;
      RREADY    = rbit();
      @(negedge ACLK);
      checkOutput("rst_no_beat", 32'(RVALID), 32'd0);
      checkOutput("rst_arready_idle", 32'(ARREADY), 32'd1);
    end
    LOC_RACK = 1'b0;
    RREADY   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ARESETn   = 1'b0;
    ARADDR    = '0;
    ARPROT    = '0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    LOC_RDATA = '0;
    LOC_RACK  = 1'b0;
    LOC_RERR  = 1'b0;
    repeat (2) @(negedge ACLK);
    checkResetValues("rst_init");
    ARESETn = 1'b1;
    @(negedge ACLK);

    applyStimulus(32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 0, 0);
    applyStimulus(32'h0000_0040, 32'h1234_5678, 1'b0, 0, 5);
    applyStimulus(32'h0000_0080, 32'hCAFE_F00D, 1'b1, 3, 1);
    applyStimulus(32'h0000_0203, 32'h0BAD_F00D, 1'b0, 1, 0);
`ifdef AXILS_RD_TIMEOUT_EN
    applyStimulus(32'h0000_0300, 32'hFEED_FACE, 1'b0, 19, 6);
    applyStimulus(32'h0000_0304, 32'h5555_AAAA, 1'b0, TO - 1, 2);
    applyStimulus(32'h0000_0308, 32'h7777_8888, 1'b1, TO, 1);
`endif
    resetMidRead();
    applyStimulus(32'h0000_0104, 32'h0102_0304, 1'b0, 2, 2);

    for (int t = 0; t < 25; t++) begin
      applyStimulus($urandom, $urandom, rbit(), int'($urandom_range(8, 0)),
                    int'($urandom_range(4, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
